// File: rtl/min_uint16_serial.sv
// rtl/min_uint16_serial.sv - bit-serial MSB-first unsigned minimum of two operands
module min_uint16_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             a_lt_b
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] I_TOP = IW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    i;
  logic             decided;
  logic             lt;

  logic bit_a;
  logic bit_b;
  logic lt_nxt;
  logic decided_nxt;

  // The first differing bit from the MSB decides; later bits cannot override it.
  always_comb begin
    bit_a       = a_q[i];
    bit_b       = b_q[i];
    decided_nxt = decided | (bit_a ^ bit_b);
    lt_nxt      = lt;
    if (!decided && (bit_a ^ bit_b)) begin
      lt_nxt = ~bit_a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      Y       <= '0;
      a_lt_b  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      i       <= I_TOP;
      decided <= 1'b0;
      lt      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            i       <= I_TOP;
            decided <= 1'b0;
            lt      <= 1'b0;
            busy    <= 1'b1;
            state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          decided <= decided_nxt;
          lt      <= lt_nxt;
          // Results are loaded on the edge into DONE so they are valid alongside done.
          if (i == '0) begin
            state  <= S_DONE;
            done   <= 1'b1;
            Y      <= lt_nxt ? a_q : b_q;
            a_lt_b <= lt_nxt;
          end else begin
            i <= i - 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_min_uint16_serial.sv
// tb/tb_min_uint16_serial.sv - randomized and directed checks of min_uint16_serial against a cycle model
module tb_min_uint16_serial;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] Y;
  logic         a_lt_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  min_uint16_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Y(Y), .a_lt_b(a_lt_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: an accepted request at cycle acc yields busy over acc+1..acc+W+1,
  // done at acc+W+1 carrying min(A,B); reset clears everything.
  bit           checking = 0;
  bit           m_active = 0;
  int           m_acc = 0;
  logic [W-1:0] m_a, m_b;
  logic [W-1:0] m_y = '0;
  logic         m_lt = 1'b0;
  int           n_acc = 0;
  bit           b2b = 0;
  int           last_done = -1;

  always @(negedge clk) begin
    bit e_busy, e_done;
    e_busy = m_active && (cyc > m_acc) && (cyc <= m_acc + W + 1);
    e_done = m_active && (cyc == m_acc + W + 1);
    if (e_done) begin
      m_y  = (m_a < m_b) ? m_a : m_b;
      m_lt = (m_a < m_b);
    end
    if (checking) begin
      check("busy", 32'(busy), 32'(e_busy));
      check("done", 32'(done), 32'(e_done));
      check("Y", 32'(Y), 32'(m_y));
      check("a_lt_b", 32'(a_lt_b), 32'(m_lt));
      if (done === 1'b1) begin
        if (b2b && last_done >= 0) check("done_spacing", 32'(cyc - last_done), 32'd18);
        last_done = cyc;
      end
    end
    if (e_done) m_active = 0;
    if (rst) begin
      m_active = 0;
      m_y      = '0;
      m_lt     = 1'b0;
      checking = 1;
    end else if (checking && start && !e_busy) begin
      m_active = 1;
      m_acc    = cyc;
      m_a      = A;
      m_b      = B;
      n_acc++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation from idle and pins the result against hand-computed values.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_y, input logic exp_lt, input string name);
    int t;
    bit seen;
    next_cycle();
    A = a; B = b; start = 1'b1;
    t = cyc;
    next_cycle();
    start = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1; break; end
    end
    check({name, "_seen"}, 32'(seen), 32'd1);
    check({name, "_lat"}, 32'(cyc - t), 32'd17);
    check({name, "_y"}, 32'(Y), 32'(exp_y));
    check({name, "_lt"}, 32'(a_lt_b), 32'(exp_lt));
  endtask

  initial begin
    int t;
    int ndone;
    int dcyc;
    int target;
    bit reached;

    // Reset then idle.
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    repeat (40) next_cycle();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_y", 32'(Y), 32'd0);

    do_op(16'h8000, 16'h7FFF, 16'h7FFF, 1'b0, "msb_a_gt");
    do_op(16'h7FFF, 16'h8000, 16'h7FFF, 1'b1, "msb_a_lt");
    do_op(16'h1234, 16'h1235, 16'h1234, 1'b1, "lsb");
    do_op(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, "equal");

    // Start while busy is ignored, as are operand changes after acceptance.
    next_cycle();
    A = 16'h0001; B = 16'h0002; start = 1'b1;
    t = cyc;
    next_cycle();
    start = 1'b0; A = 16'h0000;
    repeat (3) next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    ndone = 0;
    dcyc = -1;
    while (cyc < t + 25) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        dcyc = cyc;
        check("proto_y", 32'(Y), 32'h0001);
      end
    end
    check("proto_ndone", 32'(ndone), 32'd1);
    check("proto_lat", 32'(dcyc - t), 32'd17);

    // Reset mid-operation aborts without a done pulse.
    next_cycle();
    A = 16'h00FF; B = 16'h0F00; start = 1'b1;
    t = cyc;
    next_cycle();
    start = 1'b0;
    while (cyc < t + 8) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("abort_ndone", 32'(ndone), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_y", 32'(Y), 32'd0);
    do_op(16'h00FF, 16'h0F00, 16'h00FF, 1'b1, "after_abort");

    // Start held high with fresh random operands every cycle.
    next_cycle();
    target = n_acc + 1000;
    last_done = -1;
    b2b = 1;
    start = 1'b1;
    reached = 0;
    for (int k = 0; k < 20000; k++) begin
      A = 16'($urandom);
      case ($urandom_range(0, 7))
        0: B = A;
        1: B = A ^ 16'(1 << $urandom_range(0, 15));
        default: B = 16'($urandom);
      endcase
      next_cycle();
      if (n_acc >= target) begin reached = 1; break; end
    end
    check("random_accepts", 32'(reached), 32'd1);
    start = 1'b0;
    repeat (W + 4) next_cycle();
    b2b = 0;
    check("final_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/min_uint16_serial.md
# min_uint16_serial

Bit-serial, MSB-first unsigned minimum unit: captures two WIDTH-bit operands on `start`, examines one bit pair per cycle from MSB to LSB, and returns the smaller operand with a one-cycle `done` pulse. It is the sequential, min-direction counterpart to the combinational max/greater-than benchmarks in the pimsynth set. It models the row-serial comparison flow a processing-in-memory array executes, and lets the synthesis flow see a registered, fixed-latency datapath.

## Interface

Parameters:
- `WIDTH`, 16: operand width in bits; must be ≥ 2.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `start`: input, 1 bit. Request a comparison; accepted only when `busy`=0.
- `A`: input, WIDTH bits. Operand A, sampled on the accepting edge only.
- `B`: input, WIDTH bits. Operand B, sampled on the accepting edge only.
- `busy`: output, 1 bit. High while an operation is in flight.
- `done`: output, 1 bit. One-cycle pulse when the result is valid.
- `Y`: output, WIDTH bits. min(A,B), unsigned.
- `a_lt_b`: output, 1 bit. 1 iff A < B strictly (unsigned).

## Operation

- The FSM has three states.
  - IDLE: `busy`=0. If `start`=1, latch A→`a_q` and B→`b_q`, set bit index `i`=WIDTH-1, clear `decided` and `lt`, then go to SCAN.
  - SCAN: `busy`=1. Each cycle, examine `a_q[i]` and `b_q[i]`.
    - If `decided`=0 and the bits differ: set `decided`=1 and `lt`=(`a_q[i]`==0).
    - Once `decided`=1, all later bits are ignored.
    - If `i`==0, go to DONE; otherwise decrement `i`.
  - DONE: `busy`=1 and `done`=1 for this cycle only.
    - Register `a_lt_b`=`lt` and `Y`=`lt` ? `a_q` : `b_q`.
    - Go to IDLE.
- Equal operands: `decided` stays 0, so `a_lt_b`=0 and `Y`=B (numerically equal to A).
- Latency is fixed at WIDTH scan cycles regardless of where the first differing bit occurs. There is no early exit.
- `Y` and `a_lt_b` hold their last values until the next DONE cycle. They do not change during IDLE or SCAN.
- `start` while `busy`=1 is ignored: no effect on operands, state, or outputs. Changes to A/B after acceptance have no effect.
- Reset (`rst`=1 at a clock edge) forces IDLE and `busy`=`done`=`a_lt_b`=0, `Y`=0, `i`=WIDTH-1, `decided`=0.
  - Reset mid-SCAN aborts the operation with no `done` pulse.
  - Reset has priority over `start` on the same edge.
- The bit index counter is ceil(log2(WIDTH)) bits wide; no arithmetic wider than the index is required.

## Timing

- `start` sampled high at the end of cycle t, with `busy`=0.
- Cycles t+1 … t+WIDTH: SCAN. Cycle t+1+j examines bit WIDTH-1-j. `busy`=1.
- Cycle t+WIDTH+1: DONE. `done`=1, `busy`=1; `Y` and `a_lt_b` are valid from this cycle.
- Cycle t+WIDTH+2: IDLE, `busy`=0. The earliest next accepted `start` is sampled at the end of this cycle.
- Throughput: one result per WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- Reset then idle: assert `rst` for 2 cycles, then hold `start`=0 for 40 cycles → `busy`=`done`=`a_lt_b`=0 and `Y`=0 throughout.
- MSB decides: A=0x8000, B=0x7FFF, `start` at cycle t → `done` only at t+17, `Y`=0x7FFF, `a_lt_b`=0. Repeat with A/B swapped → `Y`=0x7FFF, `a_lt_b`=1.
- LSB decides and equality:
  - A=0x1234, B=0x1235 → `Y`=0x1234, `a_lt_b`=1.
  - A=B=0xFFFF → `Y`=0xFFFF, `a_lt_b`=0.
  - Both cases complete in exactly 17 cycles.
- Protocol robustness:
  - Pulse `start` with A=0x0001, B=0x0002, then change A to 0x0000 and pulse `start` again at t+5 → single `done` at t+17, `Y`=0x0001.
  - `start` held high continuously → accepted every 18 cycles.
- Reset mid-operation: `start` with A=0x00FF, B=0x0F00, assert `rst` at t+8 → no `done` pulse, `Y`=0, `busy`=0. A new `start` afterwards yields `Y`=0x00FF, `a_lt_b`=1 after 17 cycles.
- Randomized: 1000 random A/B pairs compared against an unsigned-min reference model, with `done` spacing checked at exactly 18 cycles under back-to-back `start`.
